// File: rtl/hazard_ctrl_pkg.sv
// Shared opcode constants and decode helpers for the decode stage and hazard control.
package hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } instr_t;

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_ctrl_load_use.sv
// Load-use comparator: flags a decode instruction that reads the register an EX-stage load writes.
// Purely combinational, zero latency, no flow control.
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       id_ex_memread,
  input  logic [4:0] id_ex_rt,
  output logic       hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (id_ex_rt == rs);
  assign rt_hit = reads_rt(opcode) && (id_ex_rt == rt);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign hazard = id_ex_memread && (id_ex_rt != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: memory-wait freeze > taken-branch flush > load-use stall.
// Controls are combinational from state and inputs; counters, wait timer and mem_err are registered.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_id_instr,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_mem_branch,
  input  logic             ex_mem_zero,
  input  logic             ex_mem_memaccess,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                WAIT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  hz_state_t         state;
  logic [WAIT_W-1:0] wait_cnt;
  instr_t            instr;
  logic              lu_hazard;
  logic              last_stall;
  logic              freeze;
  logic              branch_taken;
  logic              lu_stall;
  logic              flush_evt;
  logic              unused_imm;

  assign instr      = if_id_instr;
  assign unused_imm = ^instr.imm;

  load_use_detect u_load_use (
    .opcode        (instr.opcode),
    .rs            (instr.rs),
    .rt            (instr.rt),
    .id_ex_memread (id_ex_memread),
    .id_ex_rt      (id_ex_rt),
    .hazard        (lu_hazard)
  );

  assign freeze       = (state == RUN) ? (ex_mem_memaccess & ~dmem_ready) : ~dmem_ready;
  assign branch_taken = ex_mem_branch & ex_mem_zero;
  assign flush_evt    = branch_taken & ~freeze;
  // The bubble clears the load out of the hazard window, so a repeat the next cycle is the same hazard.
  assign lu_stall     = lu_hazard & ~last_stall & ~freeze & ~branch_taken;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_freeze  = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (freeze) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (lu_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ex_mem_memaccess && !dmem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            // Give up on the access: release the pipe and leave a sticky error.
            state   <= RUN;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      last_stall <= 1'b0;
    end else begin
      last_stall <= lu_stall;
      if (lu_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_evt && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expectations queued per cycle, checked mid-cycle against the DUT.
// A second instance with 4-bit counters exercises saturation in a short run.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  // {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze}
  localparam logic [6:0] C_NORM  = 7'b1100000;
  localparam logic [6:0] C_STALL = 7'b0010000;
  localparam logic [6:0] C_FLUSH = 7'b1101110;
  localparam logic [6:0] C_FRZ   = 7'b0000001;
  localparam logic [6:0] C_RST   = 7'b0010000;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic        mem_err;
    logic [15:0] stall;
    logic [15:0] flush;
    logic [3:0]  s_stall;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_id_instr;
  logic        id_ex_memread;
  logic [4:0]  id_ex_rt;
  logic        ex_mem_branch;
  logic        ex_mem_zero;
  logic        ex_mem_memaccess;
  logic        dmem_ready;

  logic        pc_write, if_id_write, id_ex_bubble;
  logic        if_id_flush, id_ex_flush, ex_mem_flush;
  logic        pipe_freeze, mem_err;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_if_id_write, s_id_ex_bubble;
  logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush;
  logic        s_pipe_freeze, s_mem_err;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  logic [6:0]  c_act;
  exp_t        exp_q[$];
  string       tag_q[$];
  exp_t        e;
  string       t;
  int          n_checks;
  int          n_err;

  logic [15:0] m_stall;
  logic [15:0] m_flush;
  logic [3:0]  m_sstall;
  logic        m_err;

  hazard_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_id_instr      (if_id_instr),
    .id_ex_memread    (id_ex_memread),
    .id_ex_rt         (id_ex_rt),
    .ex_mem_branch    (ex_mem_branch),
    .ex_mem_zero      (ex_mem_zero),
    .ex_mem_memaccess (ex_mem_memaccess),
    .dmem_ready       (dmem_ready),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .id_ex_bubble     (id_ex_bubble),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_flush     (ex_mem_flush),
    .pipe_freeze      (pipe_freeze),
    .mem_err          (mem_err),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut_s (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_id_instr      (if_id_instr),
    .id_ex_memread    (id_ex_memread),
    .id_ex_rt         (id_ex_rt),
    .ex_mem_branch    (ex_mem_branch),
    .ex_mem_zero      (ex_mem_zero),
    .ex_mem_memaccess (ex_mem_memaccess),
    .dmem_ready       (dmem_ready),
    .pc_write         (s_pc_write),
    .if_id_write      (s_if_id_write),
    .id_ex_bubble     (s_id_ex_bubble),
    .if_id_flush      (s_if_id_flush),
    .id_ex_flush      (s_id_ex_flush),
    .ex_mem_flush     (s_ex_mem_flush),
    .pipe_freeze      (s_pipe_freeze),
    .mem_err          (s_mem_err),
    .stall_cnt        (s_stall_cnt),
    .flush_cnt        (s_flush_cnt)
  );

  assign c_act = {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      assert (c_act === e.ctrl) else begin
        n_err++;
        $error("FAIL %s ctrl observed=%b expected=%b", t, c_act, e.ctrl);
      end
      n_checks++;
      assert (mem_err === e.mem_err) else begin
        n_err++;
        $error("FAIL %s mem_err observed=%b expected=%b", t, mem_err, e.mem_err);
      end
      n_checks++;
      assert (stall_cnt === e.stall) else begin
        n_err++;
        $error("FAIL %s stall_cnt observed=%0d expected=%0d", t, stall_cnt, e.stall);
      end
      n_checks++;
      assert (flush_cnt === e.flush) else begin
        n_err++;
        $error("FAIL %s flush_cnt observed=%0d expected=%0d", t, flush_cnt, e.flush);
      end
      n_checks++;
      assert (s_stall_cnt === e.s_stall) else begin
        n_err++;
        $error("FAIL %s sat_stall_cnt observed=%0d expected=%0d", t, s_stall_cnt, e.s_stall);
      end
    end
  end

  task automatic idle_inputs();
    if_id_instr      = 32'h0;
    id_ex_memread    = 1'b0;
    id_ex_rt         = 5'd0;
    ex_mem_branch    = 1'b0;
    ex_mem_zero      = 1'b0;
    ex_mem_memaccess = 1'b0;
    dmem_ready       = 1'b1;
  endtask

  task automatic set_load(input logic [4:0] rt, input logic [31:0] ins);
    id_ex_memread = 1'b1;
    id_ex_rt      = rt;
    if_id_instr   = ins;
  endtask

  task automatic clear_model();
    m_stall  = '0;
    m_flush  = '0;
    m_sstall = '0;
    m_err    = 1'b0;
  endtask

  // Queue this cycle's expectation, advance one clock, then fold the expected event into the counter model.
  task automatic step(input string tag, input logic [6:0] c);
    exp_t x;
    x.ctrl    = c;
    x.mem_err = m_err;
    x.stall   = m_stall;
    x.flush   = m_flush;
    x.s_stall = m_sstall;
    exp_q.push_back(x);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (c == C_STALL) begin
        if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (m_sstall != 4'hF) m_sstall = m_sstall + 4'd1;
      end
      if (c == C_FLUSH && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    clear_model();
    rst_n = 1'b0;
    idle_inputs();
    // Reset must dominate every active input.
    set_load(5'd3, 32'h002300AA);
    ex_mem_branch    = 1'b1;
    ex_mem_zero      = 1'b1;
    ex_mem_memaccess = 1'b1;
    dmem_ready       = 1'b0;
    @(posedge clk);
    #1;
    step("reset_state", C_RST);
    step("reset_hold", C_RST);
    idle_inputs();
    rst_n = 1'b1;
    step("idle", C_NORM);

    set_load(5'd3, 32'h002300AA);
    step("s1_stall", C_STALL);
    step("s1_one_cycle", C_NORM);
    idle_inputs();
    step("s1_after", C_NORM);

    set_load(5'd5, {OP_LW, 5'd1, 5'd5, 16'h0});
    step("lw_rt_not_source", C_NORM);
    set_load(5'd5, {OP_LW, 5'd5, 5'd1, 16'h0});
    step("lw_rs_hit", C_STALL);
    idle_inputs();
    step("gap_a", C_NORM);
    set_load(5'd7, {OP_SW, 5'd2, 5'd7, 16'h4});
    step("sw_rt_hit", C_STALL);
    idle_inputs();
    step("gap_b", C_NORM);
    set_load(5'd9, {OP_BEQ, 5'd1, 5'd9, 16'h0});
    step("beq_rt_hit", C_STALL);
    idle_inputs();
    step("gap_c", C_NORM);
    id_ex_rt    = 5'd3;
    if_id_instr = 32'h002300AA;
    step("no_load", C_NORM);

    set_load(5'd0, 32'h002300AA);
    step("s2_rt0", C_NORM);
    set_load(5'd0, 32'h000000AA);
    step("s2_rt0_fields0", C_NORM);

    set_load(5'd3, 32'h002300AA);
    ex_mem_branch = 1'b1;
    ex_mem_zero   = 1'b1;
    step("s3_flush", C_FLUSH);
    ex_mem_zero = 1'b0;
    step("s3_not_taken", C_STALL);
    idle_inputs();
    step("s3_after", C_NORM);

    ex_mem_memaccess = 1'b1;
    dmem_ready       = 1'b0;
    step("s4_frz1", C_FRZ);
    set_load(5'd3, 32'h002300AA);
    ex_mem_branch = 1'b1;
    ex_mem_zero   = 1'b1;
    step("s4_frz2_prio", C_FRZ);
    ex_mem_branch = 1'b0;
    ex_mem_zero   = 1'b0;
    id_ex_memread = 1'b0;
    step("s4_frz3", C_FRZ);
    dmem_ready = 1'b1;
    step("s4_release", C_NORM);
    ex_mem_memaccess = 1'b0;
    dmem_ready       = 1'b0;
    step("s4_run_probe", C_NORM);

    ex_mem_memaccess = 1'b1;
    for (int i = 0; i < 256; i++) step("s5_frozen", C_FRZ);
    ex_mem_memaccess = 1'b0;
    m_err = 1'b1;
    for (int i = 0; i < 44; i++) step("s5_timed_out", C_NORM);

    ex_mem_memaccess = 1'b1;
    step("s6_enter", C_FRZ);
    step("s6_wait", C_FRZ);
    rst_n = 1'b0;
    clear_model();
    step("s6_in_reset", C_RST);
    ex_mem_memaccess = 1'b0;
    rst_n = 1'b1;
    step("s6_run_probe", C_NORM);

    for (int i = 0; i < 21; i++) begin
      set_load(5'd3, 32'h002300AA);
      step("s6_sat_stall", C_STALL);
      idle_inputs();
      step("s6_sat_gap", C_NORM);
    end
    step("s6_final", C_NORM);

    @(negedge clk);
    #1;
    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
